// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and helpers for the CNN training datapath blocks.
//   err_state_t : control states of the output error unit.
//   fx_one()    : fixed-point value of 1.0 for a given number of fractional bits.
//   idx_width() : bit width needed to index a vector of a given length.
// -----------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } err_state_t;

    function automatic int fx_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    // A single-entry vector still needs one index bit so the port has a width.
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/sat_sub.sv
// -----------------------------------------------------------------------------
// sat_sub
// Combinational signed subtraction y = a - b with saturation to the WIDTH-bit
// signed range.
//   i_a [WIDTH] : minuend (signed)
//   i_b [WIDTH] : subtrahend (signed)
//   o_y [WIDTH] : saturated difference (signed)
// -----------------------------------------------------------------------------
module sat_sub #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_y
);

    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    // One guard bit makes the difference exact; overflow shows as the guard
    // bit disagreeing with the WIDTH-bit sign bit.
    logic signed [WIDTH:0] w_diff;
    logic                  w_ovf;

    assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_ovf  = w_diff[WIDTH] ^ w_diff[WIDTH-1];
    assign o_y    = w_ovf ? (w_diff[WIDTH] ? MIN_V : MAX_V) : w_diff[WIDTH-1:0];

endmodule

// File: rtl/output_error_unit.sv
// -----------------------------------------------------------------------------
// output_error_unit
// Turns an FCL output vector and a class label into the per-class output
// error (output - one-hot target, saturated), the argmax prediction and
// running accuracy counters. One class element is processed per cycle.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake for output_data + label
//   output_data [N]     : FCL outputs (signed WIDTH)
//   label               : true class index
//   out_valid/out_ready : result handshake
//   output_error [N]    : saturated error vector
//   predicted           : argmax index (ties -> lowest index)
//   correct, label_err  : prediction matched / label out of range
//   clear_stats         : synchronous clear of the counters
//   sample_count        : completed samples (saturating)
//   correct_count       : completed samples with correct=1 (saturating)
// -----------------------------------------------------------------------------
module output_error_unit
    import cnn_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int OUTPUT_DIM = 10,
    parameter  int FRAC_BITS  = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int IDX_W      = idx_width(OUTPUT_DIM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] output_data [OUTPUT_DIM],
    input  logic        [IDX_W-1:0] label,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] output_error [OUTPUT_DIM],
    output logic        [IDX_W-1:0] predicted,
    output logic                    correct,
    output logic                    label_err,
    input  logic                    clear_stats,
    output logic    [CNT_WIDTH-1:0] sample_count,
    output logic    [CNT_WIDTH-1:0] correct_count
);

    localparam logic signed [WIDTH-1:0] FX_ONE_V = WIDTH'(fx_one(FRAC_BITS));
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic        [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_DIM - 1);
    localparam logic        [IDX_W:0]   DIM_EXT  = (IDX_W+1)'(OUTPUT_DIM);

    err_state_t r_state;
    err_state_t w_next_state;

    logic signed [WIDTH-1:0] r_buf [OUTPUT_DIM];
    logic signed [WIDTH-1:0] r_err [OUTPUT_DIM];
    logic        [IDX_W-1:0] r_label;
    logic                    r_label_err;
    logic        [IDX_W-1:0] r_idx;
    logic signed [WIDTH-1:0] r_max;
    logic        [IDX_W-1:0] r_pred;
    logic                    r_correct;
    logic    [CNT_WIDTH-1:0] r_sample_cnt;
    logic    [CNT_WIDTH-1:0] r_correct_cnt;

    logic                    w_accept;
    logic                    w_scan;
    logic                    w_last;
    logic signed [WIDTH-1:0] w_cur;
    logic signed [WIDTH-1:0] w_target;
    logic signed [WIDTH-1:0] w_sat;
    logic                    w_gt;
    logic        [IDX_W-1:0] w_pred_final;
    logic                    w_correct_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_scan   = (r_state == SCAN);
    assign w_last   = w_scan && (r_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Per-element datapath
    // ------------------------------------------------------------------
    assign w_cur    = r_buf[r_idx];
    assign w_target = ((r_idx == r_label) && !r_label_err) ? FX_ONE_V : '0;

    sat_sub #(
        .WIDTH (WIDTH)
    ) u_sat_sub (
        .i_a (w_cur),
        .i_b (w_target),
        .o_y (w_sat)
    );

    // Strict compare keeps the earliest index on ties.
    assign w_gt           = (w_cur > r_max);
    assign w_pred_final   = w_gt ? r_idx : r_pred;
    assign w_correct_next = (w_pred_final == r_label) && !r_label_err;

    // NOTE: the input buffer has no reset; it is always loaded on the
    // acceptance edge before any element is read, so resetting it would
    // only cost reset routing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= output_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_label     <= '0;
            r_label_err <= 1'b0;
            r_idx       <= '0;
            r_max       <= MOST_NEG;
            r_pred      <= '0;
            r_correct   <= 1'b0;
            for (int k = 0; k < OUTPUT_DIM; k++) begin
                r_err[k] <= '0;
            end
        end else if (w_accept) begin
            r_label     <= label;
            r_label_err <= ({1'b0, label} >= DIM_EXT);
            r_idx       <= '0;
            r_max       <= MOST_NEG;
            r_pred      <= '0;
        end else if (w_scan) begin
            r_err[r_idx] <= w_sat;
            if (w_gt) begin
                r_max  <= w_cur;
                r_pred <= r_idx;
            end
            if (w_last) begin
                r_idx     <= '0;
                r_correct <= w_correct_next;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters: saturating, clear takes priority over the
    // increment that a coinciding final scan edge would cause.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_cnt  <= '0;
            r_correct_cnt <= '0;
        end else if (clear_stats) begin
            r_sample_cnt  <= '0;
            r_correct_cnt <= '0;
        end else if (w_last) begin
            if (r_sample_cnt != '1) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (w_correct_next && (r_correct_cnt != '1)) begin
                r_correct_cnt <= r_correct_cnt + 1'b1;
            end
        end
    end

    assign output_error  = r_err;
    assign predicted     = r_pred;
    assign correct       = r_correct;
    assign label_err     = r_label_err;
    assign sample_count  = r_sample_cnt;
    assign correct_count = r_correct_cnt;

endmodule

// File: tb/tb_output_error_unit.sv
// -----------------------------------------------------------------------------
// tb_output_error_unit
// Directed, table-driven bench for output_error_unit. A second instance with
// 4-bit counters shares all stimulus so counter saturation is reachable in a
// short run.
// -----------------------------------------------------------------------------
module tb_output_error_unit;

    localparam int W  = 16;
    localparam int N  = 10;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic clear_stats;
    logic signed [W-1:0] output_data [N];
    logic [IW-1:0] label;

    logic          in_ready;
    logic          out_valid;
    logic signed [W-1:0] output_error [N];
    logic [IW-1:0] predicted;
    logic          correct;
    logic          label_err;
    logic [15:0]   sample_count;
    logic [15:0]   correct_count;

    logic          s_in_ready;
    logic          s_out_valid;
    logic signed [W-1:0] s_output_error [N];
    logic [IW-1:0] s_predicted;
    logic          s_correct;
    logic          s_label_err;
    logic [3:0]    s_sample_count;
    logic [3:0]    s_correct_count;

    always #5 clk = ~clk;

    output_error_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .output_data   (output_data),
        .label         (label),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .output_error  (output_error),
        .predicted     (predicted),
        .correct       (correct),
        .label_err     (label_err),
        .clear_stats   (clear_stats),
        .sample_count  (sample_count),
        .correct_count (correct_count)
    );

    output_error_unit #(
        .CNT_WIDTH (4)
    ) dut_s (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .output_data   (output_data),
        .label         (label),
        .out_valid     (s_out_valid),
        .out_ready     (out_ready),
        .output_error  (s_output_error),
        .predicted     (s_predicted),
        .correct       (s_correct),
        .label_err     (s_label_err),
        .clear_stats   (clear_stats),
        .sample_count  (s_sample_count),
        .correct_count (s_correct_count)
    );

    typedef struct {
        logic signed [W-1:0] data [N];
        logic [IW-1:0]       label;
        logic signed [W-1:0] err [N];
        logic [IW-1:0]       pred;
        logic                corr;
        logic                lerr;
    } vec_t;

    vec_t vecs [5];
    int n_cmp  = 0;
    int n_bad  = 0;
    int m_samp = 0;
    int m_corr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_cnt(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? 32'(lim) : 32'(v);
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_samples"},   32'(sample_count),    sat_cnt(m_samp, 16));
        check({tag, "_corrects"},  32'(correct_count),   sat_cnt(m_corr, 16));
        check({tag, "_samples4"},  32'(s_sample_count),  sat_cnt(m_samp, 4));
        check({tag, "_corrects4"}, 32'(s_correct_count), sat_cnt(m_corr, 4));
    endtask

    // Accepts vector k, checks latency and results, optionally holds DONE
    // under backpressure for 20 cycles with fresh input traffic.
    task automatic run_vec(input int k, input bit hold);
        int n;
        check($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd1);
        output_data = vecs[k].data;
        label       = vecs[k].label;
        in_valid    = 1'b1;
        out_ready   = !hold;
        @(posedge clk); #1;
        // Scramble the inputs: the block must work from its latched copy.
        in_valid = 1'b0;
        for (int j = 0; j < N; j++) output_data[j] = 16'($urandom);
        label = 4'(k + 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("v%0d_latency", k), 32'(n), 32'd10);
        for (int j = 0; j < N; j++) begin
            check($sformatf("v%0d_err%0d", k, j), 32'(output_error[j]), 32'(vecs[k].err[j]));
        end
        check($sformatf("v%0d_pred", k),      32'(predicted), 32'(vecs[k].pred));
        check($sformatf("v%0d_correct", k),   32'(correct),   32'(vecs[k].corr));
        check($sformatf("v%0d_label_err", k), 32'(label_err), 32'(vecs[k].lerr));
        m_samp++;
        if (vecs[k].corr) m_corr++;
        check_counts($sformatf("v%0d", k));
        if (hold) begin
            for (int c = 0; c < 20; c++) begin
                in_valid = 1'b1;
                for (int j = 0; j < N; j++) output_data[j] = 16'($urandom);
                label = 4'($urandom_range(0, 9));
                @(posedge clk); #1;
                check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
                check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
                check($sformatf("bp%0d_pred", c),      32'(predicted), 32'(vecs[k].pred));
                check($sformatf("bp%0d_correct", c),   32'(correct),   32'(vecs[k].corr));
                check($sformatf("bp%0d_err", c),
                      32'(output_error[c % N]), 32'(vecs[k].err[c % N]));
            end
            in_valid = 1'b0;
            check_counts("bp_end");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("v%0d_ret_in_ready", k),  32'(in_ready),  32'd1);
        check($sformatf("v%0d_ret_out_valid", k), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        vecs[0].data = '{default: 16'sd0};
        vecs[0].data[3] = 16'sd300;
        vecs[0].label = 4'd3;
        vecs[0].err = '{default: 16'sd0};
        vecs[0].err[3] = 16'sd44;
        vecs[0].pred = 4'd3; vecs[0].corr = 1'b1; vecs[0].lerr = 1'b0;

        vecs[1].data = '{default: 16'sd5};
        vecs[1].data[0] = 16'sh8000;
        vecs[1].label = 4'd0;
        vecs[1].err = '{default: 16'sd5};
        vecs[1].err[0] = 16'sh8000;
        vecs[1].pred = 4'd1; vecs[1].corr = 1'b0; vecs[1].lerr = 1'b0;

        vecs[2].data = '{default: 16'sd100};
        vecs[2].label = 4'd12;
        vecs[2].err = '{default: 16'sd100};
        vecs[2].pred = 4'd0; vecs[2].corr = 1'b0; vecs[2].lerr = 1'b1;

        for (int j = 0; j < N; j++) vecs[3].data[j] = 16'(10 * (j + 1));
        vecs[3].data[9] = 16'sd32767;
        vecs[3].label = 4'd9;
        vecs[3].err = vecs[3].data;
        vecs[3].err[9] = 16'sd32511;
        vecs[3].pred = 4'd9; vecs[3].corr = 1'b1; vecs[3].lerr = 1'b0;

        vecs[4].data = '{default: -16'sd7};
        vecs[4].data[2] = 16'sd256;
        vecs[4].data[5] = 16'sd256;
        vecs[4].label = 4'd5;
        vecs[4].err = vecs[4].data;
        vecs[4].err[5] = 16'sd0;
        vecs[4].pred = 4'd2; vecs[4].corr = 1'b0; vecs[4].lerr = 1'b0;

        // ---------------- reset state ----------------
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
        label = '0; output_data = '{default: 16'sd0};
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pred",      32'(predicted), 32'd0);
        check("rst_correct",   32'(correct),   32'd0);
        check("rst_label_err", 32'(label_err), 32'd0);
        for (int j = 0; j < N; j++) check($sformatf("rst_err%0d", j), 32'(output_error[j]), 32'd0);
        check_counts("rst");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < 5; k++) run_vec(k, 1'b0);

        // ---------------- backpressure ----------------
        run_vec(0, 1'b1);

        // ---------------- reset mid-SCAN at i=4 ----------------
        output_data = vecs[3].data; label = vecs[3].label; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_pre_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        m_samp = 0; m_corr = 0;
        check("mid_in_ready",  32'(in_ready),  32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_pred",      32'(predicted), 32'd0);
        check("mid_correct",   32'(correct),   32'd0);
        for (int j = 0; j < N; j++) check($sformatf("mid_err%0d", j), 32'(output_error[j]), 32'd0);
        check_counts("mid");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_vec(3, 1'b0);

        // ---------------- counter saturation ----------------
        // 17 more correct samples push the 4-bit instance past all-ones.
        for (int r = 0; r < 17; r++) run_vec(0, 1'b0);

        // ---------------- clear on the final SCAN edge ----------------
        output_data = vecs[0].data; label = vecs[0].label; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("clr_pre_out_valid", 32'(out_valid), 32'd0);
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        m_samp = 0; m_corr = 0;
        check("clr_out_valid", 32'(out_valid), 32'd1);
        check("clr_correct",   32'(correct),   32'd1);
        check_counts("clr");
        @(posedge clk); #1;
        run_vec(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
